// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants and helpers for the multi-port video RAM
package vram_pkg;

    localparam int READ_LATENCY = 2;

    // Channel tags cover every video channel plus the CPU slot
    function automatic int tag_width(input int num_rd);
        return $clog2(num_rd + 1);
    endfunction

    // The CPU always occupies the slot just above the last video channel
    function automatic int cpu_tag(input int num_rd);
        return num_rd;
    endfunction

endpackage

// File: rtl/vram_rr_arbiter.sv
// rtl/vram_rr_arbiter.sv - N-slot round-robin picker with eligibility mask
module vram_rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0] elig;
    logic         found;

    assign elig = req_i & mask_i;

    // Scan from the priority slot upwards with wrap-around; first eligible slot wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && elig[j] && (((int'(ptr_i) + k) % N) == j)) begin
                    gnt_o[j] = 1'b1;
                    idx_o    = PW'(j);
                    found    = 1'b1;
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/vram_mport.sv
// rtl/vram_mport.sv - multi-client video RAM with arbitrated single-port storage
module vram_mport
    import vram_pkg::*;
#(
    parameter string MEM_INIT_FILE = "",
    parameter int    DATA_WIDTH    = 8,
    parameter int    DEPTH         = 16384,
    parameter int    ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int    NUM_RD        = 2,
    parameter int    CPU_PRIORITY  = 1,
    parameter int    MAX_WAIT      = 7
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cpu_req,
    input  logic                            cpu_we,
    input  logic [ADDRESS_WIDTH-1:0]        cpu_addr,
    input  logic [DATA_WIDTH-1:0]           cpu_din,
    input  logic [DATA_WIDTH/8-1:0]         cpu_be,
    output logic                            cpu_gnt,
    output logic                            cpu_valid,
    output logic [DATA_WIDTH-1:0]           cpu_dout,
    input  logic [NUM_RD-1:0]               rd_req,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]               rd_gnt,
    output logic [NUM_RD-1:0]               rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data
);

    localparam int NS        = NUM_RD + 1;
    localparam int TW        = tag_width(NUM_RD);
    localparam int CPU_SLOT  = cpu_tag(NUM_RD);
    localparam int LAST_SLOT = (CPU_PRIORITY != 0) ? NUM_RD - 1 : NUM_RD;
    localparam int BW        = DATA_WIDTH / 8;
    localparam int WW        = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [DATA_WIDTH-1:0]       mem [DEPTH];

    logic [TW-1:0]               ptr_q, ptr_d;
    logic [NUM_RD-1:0][WW-1:0]   wait_q, wait_d;
    logic [NUM_RD-1:0]           urgent;
    logic [NS-1:0]               urg_gnt, nrm_gnt, gnt;
    logic [TW-1:0]               urg_idx, nrm_idx, win_idx;
    logic                        urg_any, nrm_any;
    logic [ADDRESS_WIDTH-1:0]    acc_addr;
    logic                        wr_en;

    logic                        s1_valid_q;
    logic [TW-1:0]               s1_tag_q;
    logic [DATA_WIDTH-1:0]       s1_data_q;
    logic                        cpu_valid_q;
    logic [NUM_RD-1:0]           rd_valid_q;
    logic [DATA_WIDTH-1:0]       cpu_dout_q, rd_data_q;

    // A channel refused MAX_WAIT times in a row jumps ahead of the CPU
    always_comb begin
        urgent = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            urgent[i] = (MAX_WAIT != 0) && (wait_q[i] == WW'(MAX_WAIT));
        end
    end

    vram_rr_arbiter #(.N(NS), .PW(TW)) u_urg_arb (
        .req_i  ({1'b0, rd_req}),
        .mask_i ({1'b0, urgent}),
        .ptr_i  (ptr_q),
        .gnt_o  (urg_gnt),
        .idx_o  (urg_idx),
        .any_o  (urg_any)
    );

    vram_rr_arbiter #(.N(NS), .PW(TW)) u_nrm_arb (
        .req_i  ({cpu_req, rd_req}),
        .mask_i ({(CPU_PRIORITY == 0), {NUM_RD{1'b1}}}),
        .ptr_i  (ptr_q),
        .gnt_o  (nrm_gnt),
        .idx_o  (nrm_idx),
        .any_o  (nrm_any)
    );

    // Tier selection: urgent channels, then a priority CPU, then the normal round-robin
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        if (urg_any) begin
            gnt     = urg_gnt;
            win_idx = urg_idx;
        end else if ((CPU_PRIORITY != 0) && cpu_req) begin
            gnt[CPU_SLOT] = 1'b1;
            win_idx       = TW'(CPU_SLOT);
        end else if (nrm_any) begin
            gnt     = nrm_gnt;
            win_idx = nrm_idx;
        end
    end

    assign cpu_gnt = gnt[CPU_SLOT];
    assign rd_gnt  = gnt[NUM_RD-1:0];

    // Round-robin pointer advances past any slot that took part in the rotation
    always_comb begin
        ptr_d = ptr_q;
        if ((|gnt[NUM_RD-1:0]) || ((CPU_PRIORITY == 0) && gnt[CPU_SLOT])) begin
            ptr_d = (int'(win_idx) == LAST_SLOT) ? '0 : win_idx + TW'(1);
        end
    end

    // Starvation counters count refused cycles and restart on grant or idle
    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!rd_req[i] || gnt[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WW'(MAX_WAIT)) begin
                wait_d[i] = wait_q[i] + WW'(1);
            end
        end
    end

    // Address of whichever requester owns the array this cycle
    always_comb begin
        acc_addr = cpu_addr;
        for (int i = 0; i < NUM_RD; i++) begin
            if (gnt[i]) begin
                acc_addr = rd_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    assign wr_en = cpu_gnt && cpu_we && (int'(cpu_addr) < DEPTH);

    // Storage array: byte-lane CPU writes and the registered stage-1 read data
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < BW; k++) begin
                if (cpu_be[k]) begin
                    mem[cpu_addr][k*8 +: 8] <= cpu_din[k*8 +: 8];
                end
            end
        end
        s1_data_q <= mem[acc_addr];
    end

    // Arbiter state and the tag/strobe side of the two-stage return pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            wait_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= '0;
            cpu_valid_q <= 1'b0;
            rd_valid_q  <= '0;
            cpu_dout_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            wait_q      <= wait_d;
            s1_valid_q  <= (|gnt) && !(cpu_gnt && cpu_we);
            s1_tag_q    <= win_idx;
            cpu_valid_q <= s1_valid_q && (s1_tag_q == TW'(CPU_SLOT));
            for (int i = 0; i < NUM_RD; i++) begin
                rd_valid_q[i] <= s1_valid_q && (s1_tag_q == TW'(i));
            end
            if (s1_valid_q && (s1_tag_q == TW'(CPU_SLOT))) begin
                cpu_dout_q <= s1_data_q;
            end
            if (s1_valid_q && (s1_tag_q != TW'(CPU_SLOT))) begin
                rd_data_q <= s1_data_q;
            end
        end
    end

    assign cpu_valid = cpu_valid_q;
    assign cpu_dout  = cpu_dout_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_vram_mport.sv
// tb/tb_vram_mport.sv - directed and randomized checks of vram_mport against a behavioural model
module tb_vram_mport;
    import vram_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 1000;
    localparam int AW    = 10;
    localparam int NRD   = 2;
    localparam int MW    = 3;
    localparam int BW    = DW / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            cpu_req, cpu_we;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_din;
    logic [BW-1:0]   cpu_be;
    logic            cpu_gnt, cpu_valid;
    logic [DW-1:0]   cpu_dout;
    logic [NRD-1:0]  rd_req, rd_gnt, rd_valid;
    logic [NRD*AW-1:0] rd_addr;
    logic [DW-1:0]   rd_data;

    logic            bc_cpu_req;
    logic [1:0]      bc_rd_req;
    logic            b_cpu_gnt, b_cpu_valid, c_cpu_gnt, c_cpu_valid;
    logic [7:0]      b_cpu_dout, b_rd_data, c_cpu_dout, c_rd_data;
    logic [1:0]      b_rd_gnt, b_rd_valid, c_rd_gnt, c_rd_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vram_mport #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .CPU_PRIORITY(1), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_be(cpu_be),
        .cpu_gnt(cpu_gnt), .cpu_valid(cpu_valid), .cpu_dout(cpu_dout),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data)
    );

    vram_mport #(.DATA_WIDTH(8), .DEPTH(256), .NUM_RD(2), .CPU_PRIORITY(1), .MAX_WAIT(0)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(bc_cpu_req), .cpu_we(1'b0), .cpu_addr(8'h05), .cpu_din(8'h00), .cpu_be(1'b0),
        .cpu_gnt(b_cpu_gnt), .cpu_valid(b_cpu_valid), .cpu_dout(b_cpu_dout),
        .rd_req(bc_rd_req), .rd_addr(16'h0201), .rd_gnt(b_rd_gnt), .rd_valid(b_rd_valid), .rd_data(b_rd_data)
    );

    vram_mport #(.DATA_WIDTH(8), .DEPTH(256), .NUM_RD(2), .CPU_PRIORITY(0), .MAX_WAIT(0)) dut_c (
        .clk(clk), .reset(reset),
        .cpu_req(bc_cpu_req), .cpu_we(1'b0), .cpu_addr(8'h05), .cpu_din(8'h00), .cpu_be(1'b0),
        .cpu_gnt(c_cpu_gnt), .cpu_valid(c_cpu_valid), .cpu_dout(c_cpu_dout),
        .rd_req(bc_rd_req), .rd_addr(16'h0201), .rd_gnt(c_rd_gnt), .rd_valid(c_rd_valid), .rd_data(c_rd_data)
    );

    // behavioural model state
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    int            m_ptr;
    int            m_wait [NRD];
    int            q_tag [$];
    logic [DW-1:0] q_dat [$];
    int            last_w;

    // outputs sampled by the most recent cycle()
    logic          s_cpu_gnt, s_cpu_valid, s_b_cpu_gnt, s_b_cpu_valid, s_c_cpu_gnt;
    logic [NRD-1:0] s_rd_gnt, s_rd_valid;
    logic [DW-1:0] s_cpu_dout, s_rd_data;
    logic [1:0]    s_b_rd_gnt, s_b_rd_valid, s_c_rd_gnt, s_c_rd_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int c = 0; c < NRD; c++) m_wait[c] = 0;
        q_tag.delete();
        q_dat.delete();
        for (int k = 0; k < READ_LATENCY; k++) begin
            q_tag.push_back(-1);
            q_dat.push_back('x);
        end
    endtask

    // One clock cycle of dut: predict grant and return path, compare, then advance the model
    task automatic cycle();
        int w;
        int c;
        int head;
        logic [DW-1:0] hd;
        logic [AW-1:0] a;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < NRD; k++) begin
            c = (m_ptr + k) % NRD;
            if (w < 0 && rd_req[c] && m_wait[c] == MW) w = c;
        end
        if (w < 0 && cpu_req) w = NRD;
        for (int k = 0; k < NRD; k++) begin
            c = (m_ptr + k) % NRD;
            if (w < 0 && rd_req[c]) w = c;
        end
        s_cpu_gnt = cpu_gnt;  s_rd_gnt = rd_gnt;  s_cpu_valid = cpu_valid;  s_rd_valid = rd_valid;
        s_cpu_dout = cpu_dout; s_rd_data = rd_data;
        s_b_cpu_gnt = b_cpu_gnt; s_b_rd_gnt = b_rd_gnt; s_b_cpu_valid = b_cpu_valid; s_b_rd_valid = b_rd_valid;
        s_c_cpu_gnt = c_cpu_gnt; s_c_rd_gnt = c_rd_gnt; s_c_rd_valid = c_rd_valid;

        chk("cpu_gnt", 32'(cpu_gnt), 32'(w == NRD));
        chk("rd_gnt", 32'(rd_gnt), (w >= 0 && w < NRD) ? (32'd1 << w) : 32'd0);
        head = q_tag.pop_front();
        hd   = q_dat.pop_front();
        chk("cpu_valid", 32'(cpu_valid), 32'(head == NRD));
        chk("rd_valid", 32'(rd_valid), (head >= 0 && head < NRD) ? (32'd1 << head) : 32'd0);
        if (head == NRD && !$isunknown(hd)) chk("cpu_dout", 32'(cpu_dout), 32'(hd));
        if (head >= 0 && head < NRD && !$isunknown(hd)) chk("rd_data", 32'(rd_data), 32'(hd));

        if (w == NRD && cpu_we) begin
            if (int'(cpu_addr) < DEPTH) begin
                for (int b = 0; b < BW; b++) begin
                    if (cpu_be[b]) m_mem[cpu_addr][b*8 +: 8] = cpu_din[b*8 +: 8];
                end
            end
            q_tag.push_back(-1);
            q_dat.push_back('x);
        end else if (w >= 0) begin
            a = (w == NRD) ? cpu_addr : rd_addr[w*AW +: AW];
            q_tag.push_back(w);
            q_dat.push_back(m_mem[a]);
        end else begin
            q_tag.push_back(-1);
            q_dat.push_back('x);
        end

        for (int k = 0; k < NRD; k++) begin
            if (!rd_req[k] || w == k) m_wait[k] = 0;
            else if (m_wait[k] < MW) m_wait[k]++;
        end
        if (w >= 0 && w < NRD) m_ptr = (w + 1) % NRD;
        last_w = w;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        int n;
        n = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; cpu_be = be;
        do begin
            cycle();
            n++;
        end while (last_w != NRD && n < 20);
        chk("cpu_grant_timeout", 32'(last_w == NRD), 32'd1);
        cpu_req = 1'b0;
    endtask

    task automatic ch_read(input int ch, input logic [AW-1:0] a);
        int n;
        n = 0;
        rd_req[ch] = 1'b1;
        rd_addr[ch*AW +: AW] = a;
        do begin
            cycle();
            n++;
        end while (last_w != ch && n < 20);
        chk("ch_grant_timeout", 32'(last_w == ch), 32'd1);
        rd_req[ch] = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(990, 1023));
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g [8];
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_be = '0;
        rd_req = '0; rd_addr = '0;
        bc_cpu_req = 1'b0; bc_rd_req = '0;
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = 'x;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cycle();
        chk("idle_gnt", 32'({s_cpu_gnt, s_rd_gnt}), 32'd0);

        // CPU_PRIORITY=1, MAX_WAIT=0 starves channels; CPU_PRIORITY=0 rotates ch0, ch1, CPU
        bc_cpu_req = 1'b1;
        bc_rd_req  = 2'b11;
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("b_cpu_always", 32'(s_b_cpu_gnt), 32'd1);
            chk("b_ch_starved", 32'(s_b_rd_gnt), 32'd0);
            chk("c_rr_cpu", 32'(s_c_cpu_gnt), 32'(k % 3 == 2));
            chk("c_rr_ch", 32'(s_c_rd_gnt), (k % 3 < 2) ? (32'd1 << (k % 3)) : 32'd0);
            if (k >= 2) begin
                chk("b_cpu_valid_stream", 32'({s_b_cpu_valid, s_b_rd_valid}), 32'd4);
                chk("c_valid_order", 32'(s_c_rd_valid), ((k - 2) % 3 < 2) ? (32'd1 << ((k - 2) % 3)) : 32'd0);
            end
        end
        bc_cpu_req = 1'b0;
        bc_rd_req  = '0;

        // byte write then channel read with 2-cycle latency
        cpu_access(1'b1, 10'h010, 16'h00A5, 2'b01);
        ch_read(0, 10'h010);
        cycle();
        chk("lat_not_early", 32'(s_rd_valid), 32'd0);
        cycle();
        chk("ch0_valid", 32'(s_rd_valid), 32'd1);
        chk("ch0_data", 32'(s_rd_data), 32'h00A5);

        // byte-lane merge and CPU read latency
        cpu_access(1'b1, 10'h020, 16'h1234, 2'b11);
        cpu_access(1'b1, 10'h020, 16'hFF00, 2'b10);
        cpu_access(1'b0, 10'h020, 16'h0000, 2'b00);
        cycle();
        chk("cpu_lat_not_early", 32'(s_cpu_valid), 32'd0);
        cycle();
        chk("cpu_valid", 32'(s_cpu_valid), 32'd1);
        chk("cpu_merge", 32'(s_cpu_dout), 32'hFF34);

        // two channels streaming: alternating grants, valids follow with no gaps
        rd_addr = {10'h020, 10'h010};
        rd_req  = 2'b11;
        for (int k = 0; k < 8; k++) begin
            cycle();
            g[k] = s_rd_gnt;
            chk("alt_onehot", 32'(g[k] == 2'b01 || g[k] == 2'b10), 32'd1);
            if (k >= 1) chk("alt_order", 32'(g[k] ^ g[k-1]), 32'd3);
            if (k >= 2) chk("alt_valid", 32'(s_rd_valid), 32'(g[k-2]));
        end
        rd_req = '0;
        cycle();
        cycle();
        cycle();

        // CPU plus channel 1: three CPU grants then one urgent channel grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        rd_req  = 2'b10;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("urg_cpu", 32'(s_cpu_gnt), 32'(k % 4 != 3));
            chk("urg_ch1", 32'(s_rd_gnt), (k % 4 == 3) ? 32'd2 : 32'd0);
        end
        cpu_req = 1'b0;
        rd_req  = '0;
        cycle();
        cycle();

        // reset with two reads in flight: nothing returns afterwards, memory survives
        rd_req = 2'b11;
        cycle();
        cycle();
        reset  = 1'b1;
        rd_req = '0;
        @(negedge clk);
        chk("rst_flight_valid", 32'(rd_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_flight_valid2", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("post_rst_no_valid", 32'({s_cpu_valid, s_rd_valid}), 32'd0);
        end
        ch_read(0, 10'h010);
        cycle();
        cycle();
        chk("mem_kept_valid", 32'(s_rd_valid), 32'd1);
        chk("mem_kept_data", 32'(s_rd_data), 32'h00A5);

        // address beyond DEPTH still returns a strobe
        ch_read(1, 10'd1010);
        cycle();
        cycle();
        chk("oor_valid", 32'(s_rd_valid), 32'd2);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (!cpu_req && $urandom_range(0, 1) == 1) begin
                cpu_req  = 1'b1;
                cpu_we   = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr();
                cpu_din  = DW'($urandom);
                cpu_be   = BW'($urandom);
            end
            for (int c = 0; c < NRD; c++) begin
                if (!rd_req[c] && $urandom_range(0, 2) != 0) begin
                    rd_req[c] = 1'b1;
                    rd_addr[c*AW +: AW] = rand_addr();
                end
            end
            cycle();
            if (last_w == NRD) cpu_req = 1'b0;
            else if (last_w >= 0) rd_req[last_w] = 1'b0;
        end
        cpu_req = 1'b0;
        rd_req  = '0;
        cycle();
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
